// File: rtl/if_fetch_unit.sv
// Instruction fetch: one outstanding IMem request, presents PC/instruction to IF/ID.
// Latency: response in cycle N appears on PC_out/Instruction_out in cycle N+1.
// Backpressure: Stall holds outputs and blocks requests; a response during Stall parks in a one-entry buffer.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        Stall,
    input  logic        Redirect,
    input  logic [31:0] Redirect_PC,
    output logic        IMem_Req,
    output logic [31:0] IMem_Addr,
    input  logic        IMem_Ready,
    input  logic        IMem_Valid,
    input  logic [31:0] IMem_Data,
    output logic [31:0] PC_out,
    output logic [31:0] Instruction_out,
    output logic        IF_Write
);

    localparam logic [1:0] ST_REQ  = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    logic [1:0]  state;
    logic [31:0] pc;
    logic [31:0] req_pc;
    logic        buf_valid;
    logic [31:0] buf_pc;
    logic [31:0] buf_data;
    logic [31:0] redirect_tgt;
    logic        fire;

    assign redirect_tgt = Redirect_PC & 32'hFFFF_FFFC;
    assign IMem_Req     = (state == ST_REQ) & ~Stall & ~buf_valid & ~Redirect & ~RESET;
    assign IMem_Addr    = pc;
    assign fire         = IMem_Req & IMem_Ready;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state           <= ST_REQ;
            pc              <= RESET_PC;
            req_pc          <= 32'd0;
            buf_valid       <= 1'b0;
            buf_pc          <= 32'd0;
            buf_data        <= 32'd0;
            PC_out          <= 32'd0;
            Instruction_out <= 32'd0;
            IF_Write        <= 1'b0;
        end else begin
            if (Redirect) begin
                pc        <= redirect_tgt;
                buf_valid <= 1'b0;
                // An in-flight request must still be drained before the next one may issue.
                if (state == ST_WAIT || state == ST_DROP) begin
                    state <= IMem_Valid ? ST_REQ : ST_DROP;
                end
            end else begin
                case (state)
                    ST_REQ: begin
                        if (fire) begin
                            req_pc <= pc;
                            pc     <= pc + 32'd4;
                            state  <= ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        if (IMem_Valid) begin
                            state <= ST_REQ;
                            if (Stall) begin
                                buf_valid <= 1'b1;
                                buf_pc    <= req_pc;
                                buf_data  <= IMem_Data;
                            end
                        end
                    end
                    ST_DROP: begin
                        if (IMem_Valid) begin
                            state <= ST_REQ;
                        end
                    end
                    default: state <= ST_REQ;
                endcase
            end

            // IF/ID clears itself on IF_Write=0, so a stall must keep re-presenting the same values.
            if (Redirect) begin
                PC_out          <= 32'd0;
                Instruction_out <= 32'd0;
                IF_Write        <= 1'b0;
            end else if (Stall) begin
                PC_out          <= PC_out;
                Instruction_out <= Instruction_out;
                IF_Write        <= IF_Write;
            end else if (buf_valid) begin
                PC_out          <= buf_pc;
                Instruction_out <= buf_data;
                IF_Write        <= 1'b1;
                buf_valid       <= 1'b0;
            end else if (state == ST_WAIT && IMem_Valid) begin
                PC_out          <= req_pc;
                Instruction_out <= IMem_Data;
                IF_Write        <= 1'b1;
            end else begin
                PC_out          <= 32'd0;
                Instruction_out <= 32'd0;
                IF_Write        <= 1'b0;
            end
        end
    end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage that produces the values latched by the IF/ID pipeline register. It holds the program counter and issues one instruction-memory request at a time over a request/response handshake. It drives PC_out, Instruction_out and IF_Write toward IF/ID, and it handles stalls and branch redirects. Because IF/ID clears itself whenever its write enable is low, this block re-presents a held instruction during stalls and drives a deliberate bubble otherwise.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- CLK  in  1  clock; all state updates on rising edge.
- RESET  in  1  synchronous, active-high reset.
- Stall  in  1  hazard-unit hold; freezes IF/ID-facing outputs and suppresses new requests.
- Redirect  in  1  taken branch/jump; flushes fetch.
- Redirect_PC  in  32  redirect target; bits [1:0] forced to 0.
- IMem_Req  out  1  request valid (combinational).
- IMem_Addr  out  32  request address, equals internal pc.
- IMem_Ready  in  1  memory accepts request when IMem_Req & IMem_Ready.
- IMem_Valid  in  1  response valid; exactly one response per accepted request, earliest 1 cycle after accept.
- IMem_Data  in  32  instruction word, valid with IMem_Valid.
- PC_out  out  32  address of presented instruction (to IF/ID PC).
- Instruction_out  out  32  presented instruction (to IF/ID Instruction).
- IF_Write  out  1  to IF/ID Write; 1 = latch PC_out/Instruction_out, 0 = bubble.

## Operation
- State: pc, req_pc (address of outstanding request), FSM {REQ, WAIT, DROP}, one-entry buffer (buf_valid, buf_pc, buf_data).
- IMem_Req = (state==REQ) & !Stall & !buf_valid & !Redirect & !RESET.
- REQ: on IMem_Req & IMem_Ready: req_pc<=pc, pc<=pc+4 (mod 2^32), go to WAIT. IMem_Valid is ignored in REQ.
- WAIT, IMem_Valid, no Redirect: if Stall=1, store (req_pc, IMem_Data) in the buffer; otherwise load the outputs directly. Go to REQ in both cases.
- WAIT, Redirect without IMem_Valid: go to DROP.
- WAIT, Redirect with IMem_Valid: discard the data and go to REQ.
- DROP: wait for IMem_Valid, discard the data, go to REQ. A further Redirect in DROP only updates pc.
- Redirect (any state): pc<={Redirect_PC[31:2],2'b00}, buffer cleared, outputs flushed. Redirect has priority over Stall and over response capture.
- Output register update, in priority order:
  - RESET or Redirect: PC_out=0, Instruction_out=0, IF_Write=0.
  - Stall=1: all three outputs hold their value, so IF/ID re-latches the same instruction (or keeps the bubble).
  - buf_valid: outputs<=buffer, IF_Write=1, buffer emptied.
  - WAIT & IMem_Valid: PC_out<=req_pc, Instruction_out<=IMem_Data, IF_Write=1.
  - Otherwise: bubble; PC_out=0, Instruction_out=0, IF_Write=0.
- At most one request outstanding. The buffer never overflows because Stall and buf_valid both block new requests.

## Timing
- Reset values: pc=RESET_PC, state=REQ, buf_valid=0, PC_out=0, Instruction_out=0, IF_Write=0, IMem_Req=0 during the reset cycle.
- First request is issued in the first cycle with RESET=0 and Stall=0.
- Latency: response in cycle N puts the instruction on the outputs in cycle N+1.
- Throughput: one instruction per 2 cycles with 1-cycle memory (accept, respond). A bubble cycle appears between instructions.
- Redirect in cycle N: IF_Write=0 in N+1; earliest new request at Redirect_PC in N+1.
- RESET during WAIT or DROP: the late response arrives while in REQ and is ignored.
- Stall release in cycle N with buf_valid: buffered instruction is presented in N+1, and a new request is issued in N+1.

## Test plan
- Reset, RESET_PC=0, 1-cycle memory returning addr+0x1000 -> requests at 0,4,8. Outputs show (PC_out=0, Instr=0x1000, IF_Write=1), then a bubble with all outputs 0, then (4, 0x1004, 1), and so on.
- Response 0xAAAA for address 4 arrives while Stall=1 -> outputs keep the previous instruction with IF_Write unchanged and IMem_Req=0. Cycle after Stall drops: PC_out=4, Instr=0xAAAA, IF_Write=1.
- Redirect to 0x100 while in WAIT -> IF_Write=0 next cycle. Returning data is discarded (DROP). Next request is at 0x100, and PC_out=0x100 when its response arrives.
- Redirect to 0x200 coinciding with IMem_Valid and Stall=1 -> data discarded, outputs flushed to 0, buffer empty, next request at 0x200.
- Redirect_PC=0x103 -> IMem_Addr=0x100. Redirect_PC=0xFFFF_FFFC -> next two addresses 0xFFFF_FFFC, 0x0000_0000.
- RESET asserted in WAIT, IMem_Valid arrives the following cycle -> outputs stay 0 and IF_Write stays 0. First request after reset is at RESET_PC.
